// File: rtl/cla_pipe_adder.sv
// Pipelined Kogge-Stone carry-lookahead adder/subtractor with a valid/ready stream interface.
// Optional macro CLA_PIPE_SAT_EN: saturate out_s on signed overflow instead of wrapping.
module cla_pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LPS    = (LEVELS + STAGES - 1) / STAGES;

    // Applies prefix-tree levels lo..hi-1 to a running {generate, propagate} pair.
    function automatic logic [2*WIDTH-1:0] prefix_levels(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g_prev;
        logic [WIDTH-1:0] p_prev;
        g      = g_in;
        p      = p_in;
        g_prev = g_in;
        p_prev = p_in;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= lo && l < hi) begin
                g_prev = g;
                p_prev = p;
                for (int i = (1 << l); i < WIDTH; i++) begin
                    g[i] = g_prev[i] | (p_prev[i] & g_prev[i - (1 << l)]);
                    p[i] = p_prev[i] & p_prev[i - (1 << l)];
                end
            end
        end
        return {g, p};
    endfunction

    // Handshake: input transfers when in_valid & in_ready; output transfers when
    // out_valid & out_ready. The whole pipe freezes only while a result waits unread.
    logic stall;
    logic adv;
    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    assign b_eff = in_sub ? ~in_b : in_b;

    // Inputs to the final segment, from the ports or from the last internal register.
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [WIDTH-1:0] last_g;
    logic [WIDTH-1:0] last_p;
    logic             last_cin;
    logic             last_v;

    if (STAGES == 1) begin : g_direct
        assign last_a   = in_a;
        assign last_b   = b_eff;
        assign last_g   = in_a & b_eff;
        assign last_p   = in_a ^ b_eff;
        assign last_cin = in_carry;
        assign last_v   = in_valid;
    end else begin : g_pipe
        localparam int NR = STAGES - 1;

        logic [WIDTH-1:0] r_a   [NR];
        logic [WIDTH-1:0] r_b   [NR];
        logic [WIDTH-1:0] r_g   [NR];
        logic [WIDTH-1:0] r_p   [NR];
        logic             r_cin [NR];
        logic             r_v   [NR];
        logic [WIDTH-1:0] n_g   [NR];
        logic [WIDTH-1:0] n_p   [NR];

        always_comb begin
            {n_g[0], n_p[0]} = prefix_levels(in_a & b_eff, in_a ^ b_eff, 0, LPS);
            for (int k = 1; k < NR; k++) begin
                {n_g[k], n_p[k]} = prefix_levels(r_g[k-1], r_p[k-1], k * LPS, (k + 1) * LPS);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NR; k++) begin
                    r_a[k]   <= '0;
                    r_b[k]   <= '0;
                    r_g[k]   <= '0;
                    r_p[k]   <= '0;
                    r_cin[k] <= 1'b0;
                    r_v[k]   <= 1'b0;
                end
            end else if (adv) begin
                r_a[0]   <= in_a;
                r_b[0]   <= b_eff;
                r_g[0]   <= n_g[0];
                r_p[0]   <= n_p[0];
                r_cin[0] <= in_carry;
                r_v[0]   <= in_valid;
                for (int k = 1; k < NR; k++) begin
                    r_a[k]   <= r_a[k-1];
                    r_b[k]   <= r_b[k-1];
                    r_g[k]   <= n_g[k];
                    r_p[k]   <= n_p[k];
                    r_cin[k] <= r_cin[k-1];
                    r_v[k]   <= r_v[k-1];
                end
            end
        end

        assign last_a   = r_a[NR-1];
        assign last_b   = r_b[NR-1];
        assign last_g   = r_g[NR-1];
        assign last_p   = r_p[NR-1];
        assign last_cin = r_cin[NR-1];
        assign last_v   = r_v[NR-1];
    end

    logic [WIDTH-1:0] fin_g;
    logic [WIDTH-1:0] fin_p;
    logic [WIDTH:0]   carries;
    logic [WIDTH-1:0] fin_s;
    logic             fin_ovf;

    // Final segment: remaining tree levels, carry injection, sum XOR and optional saturation.
    always_comb begin
        {fin_g, fin_p} = prefix_levels(last_g, last_p, (STAGES - 1) * LPS, STAGES * LPS);
        carries[0] = last_cin;
        for (int i = 1; i <= WIDTH; i++) begin
            carries[i] = fin_g[i-1] | (fin_p[i-1] & last_cin);
        end
        fin_s   = (last_a ^ last_b) ^ carries[WIDTH-1:0];
        fin_ovf = carries[WIDTH] ^ carries[WIDTH-1];
`ifdef CLA_PIPE_SAT_EN
        if (fin_ovf) begin
            fin_s = last_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Result fields load only with a valid op, so they keep their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_s        <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
        end else if (adv) begin
            out_valid <= last_v;
            if (last_v) begin
                out_s        <= fin_s;
                out_carry    <= carries[WIDTH];
                out_overflow <= fin_ovf;
            end
        end
    end

endmodule
